// File: rtl/add8u_share_sched.sv
// add8u_share_sched: round-robin time-sharing of one external 8u adder among NREQ requesters.
// Defining ADD8U_SCHED_ERRCHK_EN adds an exact-adder checker driving rsp_err/err_cnt.
module add8u_share_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  input  logic [8:0]        add_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [8:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err,
  output logic [15:0]       err_cnt
);
  logic           s1_v, s2_adv, s1_free, found, acc;
  logic [IDW-1:0] s1_id, ptr, win;
  // scan downward so the lowest offset from ptr is the one left standing
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win = IDW'((int'(ptr) + k) % NREQ);
      end
  end
  assign s2_adv    = !rsp_valid | rsp_ready;
  assign s1_free   = !s1_v | s2_adv;
  assign acc       = rst_n & found & s1_free;
  assign req_ready = acc ? NREQ'(1) << win : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_id <= '0;
      ptr <= '0;
      add_a <= '0;
      add_b <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
    end else begin
      if (acc) begin
        add_a <= req_a[8*win +: 8];
        add_b <= req_b[8*win +: 8];
        s1_id <= win;
        s1_v <= 1'b1;
        ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      end else if (s1_free) begin
        s1_v <= 1'b0;
      end
      if (s2_adv) begin
        rsp_valid <= s1_v;
        if (s1_v) begin
          rsp_data <= add_o;
          rsp_id <= s1_id;
        end
      end
    end
  end
`ifdef ADD8U_SCHED_ERRCHK_EN
  logic [8:0] exact;
  assign exact = {1'b0, add_a} + {1'b0, add_b};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
      err_cnt <= '0;
    end else if (s2_adv & s1_v) begin
      rsp_err <= add_o != exact;
      if (add_o != exact && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_add8u_share_sched.sv
// tb_add8u_share_sched: directed + random checks against a transaction-level scoreboard.
module tb_add8u_share_sched;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n, rr, force1;
  logic [N-1:0] vv, taken, req_ready;
  logic [7:0] va[N], vb[N];
  logic [8*N-1:0] pa, pb;
  logic [7:0] add_a, add_b;
  logic [8:0] add_o, rsp_data;
  logic rsp_valid, rsp_err;
  logic [1:0] rsp_id;
  logic [15:0] err_cnt;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  always_comb begin
    pa = '0;
    pb = '0;
    for (int i = 0; i < N; i++) begin
      pa[8*i +: 8] = va[i];
      pb[8*i +: 8] = vb[i];
    end
  end
  // the shared adder: exact, or with bit 0 forced high
  assign add_o = ({1'b0, add_a} + {1'b0, add_b}) | {8'b0, force1};
  add8u_share_sched #(.NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(vv), .req_ready(req_ready),
    .req_a(pa), .req_b(pb), .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .err_cnt(err_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct {int id; logic [8:0] sum; logic [8:0] ex; int c; bit shown;} ent_t;
  ent_t q[$];
  int mptr, cyc, merr, mw;
  logic [7:0] la, lb;
  logic [N-1:0] mrdy;
  bit mv;
  // scoreboard: oldest in-flight op appears two cycles after its accept, in order
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mptr = 0; cyc = 0; merr = 0; la = 0; lb = 0; taken = '0;
    end else begin
      cyc++;
      mw = -1;
      for (int k = 0; k < N; k++)
        if (mw < 0 && vv[(mptr + k) % N]) mw = (mptr + k) % N;
      mrdy = (mw >= 0 && (q.size() < 2 || rr)) ? N'(1) << mw : '0;
      check("req_ready", req_ready, mrdy);
      check("add_a", add_a, la);
      check("add_b", add_b, lb);
      mv = q.size() > 0 && cyc - q[0].c >= 2;
      check("rsp_valid", rsp_valid, mv);
      if (mv) begin
        if (!q[0].shown) begin
          q[0].shown = 1;
          if (q[0].sum != q[0].ex && merr < 65535) merr++;
        end
        check("rsp_data", rsp_data, q[0].sum);
        check("rsp_id", rsp_id, q[0].id);
`ifdef ADD8U_SCHED_ERRCHK_EN
        check("rsp_err", rsp_err, q[0].sum != q[0].ex);
`endif
      end
`ifdef ADD8U_SCHED_ERRCHK_EN
      check("err_cnt", err_cnt, merr);
`else
      check("rsp_err_tie", rsp_err, 0);
      check("err_cnt_tie", err_cnt, 0);
`endif
      taken = mrdy;
      if (mv && rr) void'(q.pop_front());
      if (mrdy != 0) begin
        q.push_back('{mw, (9'(va[mw]) + 9'(vb[mw])) | {8'b0, force1}, 9'(va[mw]) + 9'(vb[mw]), cyc, 0});
        mptr = (mw + 1) % N;
        la = va[mw];
        lb = vb[mw];
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1 vv = vv & ~taken;
  endtask
  task automatic reset_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    vv = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_add_a"}, add_a, 0);
    check({tag, "_add_b"}, add_b, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask
  initial begin
    rst_n = 1'b0; rr = 1'b1; force1 = 1'b0; vv = '0;
    for (int i = 0; i < N; i++) begin va[i] = 8'h0; vb[i] = 8'h0; end
    #12 vv = '1;
    #1 check_zero("reset");
    vv = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    va[2] = 8'h7F; vb[2] = 8'h01; vv[2] = 1'b1;
    tick();
    check("single_add_a", add_a, 8'h7F);
    check("single_add_b", add_b, 8'h01);
    tick();
    check("single_valid", rsp_valid, 1);
    check("single_data", rsp_data, 9'h080);
    check("single_id", rsp_id, 2);
    repeat (3) tick();
    reset_pulse();
    for (int i = 0; i < N; i++) begin va[i] = 8'hFF; vb[i] = 8'hFF; end
    for (int k = 0; k < 8; k++) begin
      vv = '1;
      #1 check("fair_grant", req_ready, N'(1) << (k % N));
      tick();
    end
    vv = '0;
    check("max_sum", rsp_data, 9'h1FE);
    repeat (3) tick();
    reset_pulse();
    rr = 1'b0;
    for (int i = 0; i < 3; i++) begin va[i] = 8'(8'h10 * i + 3); vb[i] = 8'(8'h21 + i); end
    vv = 4'b0111;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_ready", req_ready, 0);
      tick();
    end
    rr = 1'b1;
    repeat (6) tick();
    check("bp_drain", q.size(), 0);
    rr = 1'b0;
    va[0] = 8'h3C; vb[0] = 8'h5A; va[1] = 8'h81; vb[1] = 8'h7E;
    vv = 4'b0011;
    tick();
    tick();
    #2 rst_n = 1'b0;
    vv = '0;
    #1 check_zero("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    rr = 1'b1;
    va[3] = 8'h01; vb[3] = 8'h02; vv = 4'b1001;
    #1 check("first_grant", req_ready, 4'b0001);
    repeat (5) tick();
    va[1] = 8'h55; vb[1] = 8'hAA; vv[1] = 1'b1;
    repeat (6) tick();
    check("idle_a", add_a, 8'h55);
    check("idle_b", add_b, 8'hAA);
    force1 = 1'b1;
    va[0] = 8'd2; vb[0] = 8'd2; vv[0] = 1'b1;
    tick();
    tick();
    check("approx_data", rsp_data, 9'd5);
`ifdef ADD8U_SCHED_ERRCHK_EN
    check("approx_err", rsp_err, 1);
    check("approx_cnt", err_cnt, 1);
`endif
    repeat (3) tick();
    force1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!vv[i] && $urandom_range(1) == 0) begin
          va[i] = 8'($urandom);
          vb[i] = 8'($urandom);
          vv[i] = 1'b1;
        end
      rr = $urandom_range(3) != 0;
      tick();
    end
    vv = '0;
    rr = 1'b1;
    repeat (5) tick();
    check("final_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/add8u_share_sched.md
# add8u_share_sched

Round-robin scheduler that time-shares one combinational 8-bit unsigned adder (exact or any approximate 8u library adder) among `NREQ` requesters. Each requester submits an operand pair over a valid/ready handshake. The block registers the granted pair onto the external adder's inputs, captures the 9-bit sum one cycle later, and returns it tagged with the requester ID. It sits between accelerator lanes and a single shared adder instance, trading throughput for area and power.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: width of the response ID.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept, at most one bit high.
- `req_a` in 8*NREQ: operand A, requester i at bits [8i+7:8i].
- `req_b` in 8*NREQ: operand B, same packing as `req_a`.
- `add_a` out 8: registered operand A to the shared adder.
- `add_b` out 8: registered operand B to the shared adder.
- `add_o` in 9: shared adder sum, combinational from `add_a`/`add_b`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer accept.
- `rsp_data` out 9: captured sum.
- `rsp_id` out IDW: index of the requester that issued the operands.
- `rsp_err` out 1: `add_o` differed from the exact A+B. Only with the macro (see Configuration).
- `err_cnt` out 16: saturating mismatch count. Only with the macro.

## Operation
- Two pipeline stages:
  - S1 (operand stage): `s1_v`, `s1_id`, `add_a`, `add_b`.
  - S2 (response stage): `rsp_valid`, `rsp_data`, `rsp_id`.
- Advance conditions:
  - `s2_adv = !rsp_valid | rsp_ready`
  - `s1_free = !s1_v | s2_adv`
- Arbitration:
  - Round-robin pointer `ptr` (IDW bits, reset 0).
  - Search order is ptr, ptr+1, …, ptr+NREQ-1 (mod NREQ). The first index with `req_valid` set wins.
  - `req_ready[win] = s1_free`. All other `req_ready` bits are 0. `req_ready` combinationally depends on `req_valid` and `rsp_ready`.
- Accept (`req_valid[i] & req_ready[i]`):
  - `add_a`/`add_b` load that requester's operands.
  - `s1_id` is set to i and `s1_v` is set to 1.
  - `ptr` becomes (i+1) mod NREQ.
- When S1 is free and there is no accept, `s1_v` is cleared. `add_a`/`add_b` hold their last values, so the adder inputs do not toggle while idle.
- When `s2_adv` and `s1_v`: `rsp_data` loads `add_o`, `rsp_id` loads `s1_id`, and `rsp_valid` is set to 1.
- When `s2_adv` and `!s1_v`: `rsp_valid` is cleared.
- While `rsp_valid & !rsp_ready`: S2 holds. S1 also holds, and `req_ready` stays all 0.
- Arithmetic: `rsp_data` is exactly `add_o`. The block never corrects an approximate result.
- Every accepted request produces exactly one response, in acceptance order.

## Timing
- Reset values (asynchronous, while `rst_n` = 0): `s1_v`, `rsp_valid`, `ptr`, `add_a`, `add_b`, `rsp_data`, `rsp_id`, `rsp_err`, `err_cnt` are all 0. `req_ready` is 0.
- Latency: request accepted at edge T → `add_a`/`add_b` valid after T → `rsp_valid` = 1 after edge T+1. That is 2 cycles.
- Throughput: one accept per cycle while `rsp_ready` = 1.
- The consumer may drop `rsp_ready` at any time. `rsp_data`/`rsp_id` stay stable while `rsp_valid & !rsp_ready`.
- At most 2 requests are in flight.
- Reset asserted mid-operation: in-flight operations are discarded and no response is issued. After release, arbitration starts again at requester 0.

## Configuration
- `ADD8U_SCHED_ERRCHK_EN` defined:
  - An internal exact adder computes `add_a + add_b` alongside the shared adder.
  - On each S2 load, `rsp_err` = (`add_o` ≠ exact).
  - `err_cnt` increments on each S2 load with a mismatch and saturates at 0xFFFF.
- Not defined:
  - `rsp_err` and `err_cnt` are tied to 0.
  - No exact adder is instantiated.

## Test plan
- Single request: requester 2 sends A=0x7F, B=0x01 with an exact adder and `rsp_ready`=1 → `rsp_valid` 2 cycles later with `rsp_data`=0x080, `rsp_id`=2.
- Fairness: all 4 requesters hold valid continuously with `rsp_ready`=1 → grants go 0,1,2,3,0,… one per cycle. Max sum 0xFF+0xFF returns 0x1FE.
- Backpressure: 3 back-to-back requests with `rsp_ready`=0 for 5 cycles → two are held and `req_ready` stays 0. After release, three responses come out in order with no loss or duplication.
- Reset mid-flight: `rst_n` pulled low asynchronously with S1 and S2 full → all outputs 0 immediately. No response appears after release, and the first grant goes to requester 0.
- Idle hold: after a request with A=0x55, B=0xAA and no further valid requests → `add_a`=0x55 and `add_b`=0xAA stay constant.
- With the macro: connect an adder that forces O[0]=1 and send A=2, B=2 → `rsp_data`=5, `rsp_err`=1, `err_cnt`=1. An exact adder gives `err_cnt` = 0.
